// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns stage.
// A 128-bit state is latched on an En_IMC request and transformed COLS_PER_CYCLE
// columns per clock. The finished state is published atomically on Out_IMC
// together with Ry_IMC. The result then holds until En_IMC drops.
module inv_mix_columns #(
    parameter int COLS_PER_CYCLE = 1    // 1, 2 or 4
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En_IMC,
    output logic         Ry_IMC,
    output logic         Busy_IMC,
    input  logic [127:0] In_IMC,
    output logic [127:0] Out_IMC
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // The counter always holds a multiple of COLS_PER_CYCLE. The step that
    // starts at column 4-COLS_PER_CYCLE is therefore the one that finishes column 3.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_t        state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic [127:0]  work_reg, work_next;
    logic [127:0]  out_reg, out_next;
    logic          ry_reg, ry_next;
    logic          busy_reg, busy_next;

    logic [1:0]    col_idx [COLS_PER_CYCLE];
    logic [31:0]   mixed   [COLS_PER_CYCLE];
    logic [127:0]  work_upd;
    logic          last_step;

    // GF(2^8) multiply by x, reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // The inverse column transform. Every coefficient is built from the
    // x2/x4/x8 chain of the same byte:
    //   09 = x8^1, 0b = x8^x2^1, 0d = x8^x4^1, 0e = x8^x4^x2
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Gather column c from the row-major state. Byte (r,c) sits at [127-8*(4r+c) -: 8].
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] col;
        col = '0;
        for (int r = 0; r < 4; r++) begin
            col[31-8*r -: 8] = s[127-8*(4*r+int'(c)) -: 8];
        end
        return col;
    endfunction

    // One transform lane per column handled this cycle
    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign col_idx[gi] = cnt_reg + 2'(gi);
            assign mixed[gi]   = inv_mix_col(get_col(work_reg, col_idx[gi]));
        end
    endgenerate

    assign last_step = (cnt_reg == LAST_CNT);

    // Scatter the transformed columns back into a copy of the working state
    always_comb begin
        work_upd = work_reg;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            for (int r = 0; r < 4; r++) begin
                work_upd[127-8*(4*r+int'(col_idx[i])) -: 8] = mixed[i][31-8*r -: 8];
            end
        end
    end

    // Next-state and next-output logic of the IDLE/BUSY/DONE sequencer
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        work_next  = work_reg;
        out_next   = out_reg;
        ry_next    = ry_reg;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                ry_next = 1'b0;
                if (En_IMC) begin
                    work_next  = In_IMC;
                    cnt_next   = 2'd0;
                    busy_next  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                work_next = work_upd;
                cnt_next  = cnt_reg + CNT_STEP;
                if (last_step) begin
                    // Publish the whole result in one update; no partial state leaks out
                    out_next   = work_upd;
                    ry_next    = 1'b1;
                    busy_next  = 1'b0;
                    cnt_next   = 2'd0;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Hold until En drops, so a new run needs a fresh low-to-high request
                if (!En_IMC) begin
                    ry_next    = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ry_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any run in progress
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            work_reg  <= '0;
            out_reg   <= '0;
            ry_reg    <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            work_reg  <= work_next;
            out_reg   <= out_next;
            ry_reg    <= ry_next;
            busy_reg  <= busy_next;
        end
    end

    assign Ry_IMC   = ry_reg;
    assign Busy_IMC = busy_reg;
    assign Out_IMC  = out_reg;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Scoreboard bench for inv_mix_columns. Three instances are built, with 1, 2 and
// 4 columns per cycle. Stimulus pushes the expected result, latency and busy
// length for each run. A monitor checks all instances shortly after every
// rising edge.
module tb_inv_mix_columns;

    localparam logic [127:0] FIPS_IN  = 128'h04e0482866cbf8068119d326e59a7a4c;
    localparam logic [127:0] FIPS_OUT = 128'hd4e0b81ebfb441275d52119830aef1e5;
    localparam logic [127:0] UNI_IN   = 128'h8e8e8e8e4d4d4d4da1a1a1a1bcbcbcbc;
    localparam logic [127:0] UNI_OUT  = 128'hdbdbdbdb131313135353535345454545;
    localparam logic [127:0] ONES     = 128'h01010101010101010101010101010101;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic [2:0]   en;
    logic [2:0]   ry;
    logic [2:0]   busy;
    logic [127:0] dout [3];

    typedef struct {
        int           dut;
        logic [127:0] data;
        int           start;
        int           lat;
        int           bcnt;
    } exp_t;

    exp_t         sb [$];
    exp_t         e;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [2:0]   ry_prev = 3'b000;
    logic [127:0] model [3];
    int           bc [3];

    always #5 clk = ~clk;

    inv_mix_columns #(.COLS_PER_CYCLE(1)) dut0 (
        .Clk(clk), .Rst(rst), .En_IMC(en[0]), .Ry_IMC(ry[0]),
        .Busy_IMC(busy[0]), .In_IMC(din), .Out_IMC(dout[0]));
    inv_mix_columns #(.COLS_PER_CYCLE(2)) dut1 (
        .Clk(clk), .Rst(rst), .En_IMC(en[1]), .Ry_IMC(ry[1]),
        .Busy_IMC(busy[1]), .In_IMC(din), .Out_IMC(dout[1]));
    inv_mix_columns #(.COLS_PER_CYCLE(4)) dut2 (
        .Clk(clk), .Rst(rst), .En_IMC(en[2]), .Ry_IMC(ry[2]),
        .Busy_IMC(busy[2]), .In_IMC(din), .Out_IMC(dout[2]));

    task automatic chk(input string name, input int k,
                       input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got %h required %h", name, k, act, req);
        end
    endtask

    function automatic int cols_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    // Raise En on instance k and record what its completion must look like
    task automatic start_op(input int k, input logic [127:0] v, input logic [127:0] x);
        exp_t n;
        n.dut   = k;
        n.data  = x;
        n.start = cyc;
        n.lat   = 1 + 4 / cols_of(k);
        n.bcnt  = 4 / cols_of(k);
        sb.push_back(n);
        din   = v;
        en[k] = 1'b1;
        $display("op dut%0d in=%h expect=%h", k, v, x);
    endtask

    task automatic wait_ry(input int k);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ry[k]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ry_timeout dut%0d: got ry=0 required ry=1 within 16 cycles", k);
        end
    endtask

    task automatic run(input int k, input logic [127:0] v, input logic [127:0] x, input int hold);
        start_op(k, v, x);
        wait_ry(k);
        repeat (hold) @(negedge clk);
        en[k] = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        for (int k = 0; k < 3; k++) begin
            model[k] = '0;
            bc[k]    = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    chk("rst_ry", k, ry[k], 0);
                    chk("rst_busy", k, busy[k], 0);
                    chk("rst_out", k, dout[k], 0);
                    model[k] = '0;
                    bc[k]    = 0;
                end else begin
                    chk("ry_busy_excl", k, ry[k] & busy[k], 0);
                    if (ry[k] && !ry_prev[k]) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ry dut%0d: got ry=1 required no completion", k);
                        end else begin
                            e = sb.pop_front();
                            chk("sb_dut", k, e.dut, k);
                            chk("result", k, dout[k], e.data);
                            chk("latency", k, cyc - e.start, e.lat);
                            chk("busy_cycles", k, bc[k], e.bcnt);
                            $display("done dut%0d out=%h latency=%0d", k, dout[k], cyc - e.start);
                            model[k] = e.data;
                        end
                    end else begin
                        chk("out_hold", k, dout[k], model[k]);
                        if (ry_prev[k]) chk("ry_follows_en", k, ry[k], en[k]);
                    end
                    if (busy[k]) bc[k]++;
                    else bc[k] = 0;
                end
                ry_prev[k] = ry[k];
            end
            if (rst) sb.delete();
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        en  = 3'b001;           // reset must win over a pending request
        din = FIPS_IN;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 3'b000;
        @(negedge clk);

        // FIPS-197 round-1 vector, then hold En to see Ry stay up
        run(0, FIPS_IN, FIPS_OUT, 2);

        // Uniform columns on every lane width
        run(0, UNI_IN, UNI_OUT, 0);
        run(1, UNI_IN, UNI_OUT, 0);
        run(2, UNI_IN, UNI_OUT, 0);

        // Identity and zero with En held high: no re-trigger
        run(0, ONES, ONES, 3);
        run(0, 128'h0, 128'h0, 3);

        // Input change and En drop on the second busy edge must not matter
        start_op(0, FIPS_IN, FIPS_OUT);
        @(negedge clk);
        @(negedge clk);
        din   = 128'hdeadbeef0123456789abcdeffedcba98;
        en[0] = 1'b0;
        wait_ry(0);
        @(negedge clk);

        // Reset on the third busy edge aborts with no result exposed
        start_op(0, UNI_IN, UNI_OUT);
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_after_abort", 0, {ry[0], busy[0]}, 0);
        chk("out_after_abort", 0, dout[0], 0);

        // Back-to-back: result holds until the next completion
        run(0, FIPS_IN, FIPS_OUT, 0);
        run(0, 128'h0, 128'h0, 0);
        repeat (2) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d pending required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
